multicycle_control_fsm: RTL and testbench

Multicycle control sequencer for the RV32I core. It walks each instruction through fetch, decode, execute, memory and writeback steps, and drives the datapath enables and multiplexer selects for each step. It generates the 2-bit ALU class code and the immediate flag consumed by `ALU_Control`. It sits between the instruction register (opcode) and the shared single-port instruction/data memory (ready handshake).

---
 rtl/multicycle_control_fsm.sv | 275 +++++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer for the RV32I core: steps each instruction through
// fetch/decode/execute/memory/writeback and drives datapath enables and selects.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] instruction_opcode_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       pc_source_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_write_o,
    output logic [1:0] mem_to_reg_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_co_o,
    output logic       is_immediate_o,
    output logic       instr_done_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMREAD  = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXEC_R   = 4'd6;
    localparam logic [3:0] ST_EXEC_I   = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;
    localparam logic [3:0] ST_JAL      = 4'd10;
    localparam logic [3:0] ST_JALR     = 4'd11;
    localparam logic [3:0] ST_JALR_WB  = 4'd12;
    localparam logic [3:0] ST_LUI      = 4'd13;
    localparam logic [3:0] ST_AUIPC    = 4'd14;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Maps a decoded opcode to the first execution state; unsupported opcodes return FETCH.
    function automatic logic [3:0] decode_target(input logic [6:0] op);
        logic [3:0] tgt;
        case (op)
            OP_LOAD:   tgt = ST_MEMADR;
            OP_STORE:  tgt = ST_MEMADR;
            OP_RTYPE:  tgt = ST_EXEC_R;
            OP_ITYPE:  tgt = ST_EXEC_I;
            OP_BRANCH: tgt = ST_BRANCH;
            OP_JAL:    tgt = ST_JAL;
            OP_JALR:   tgt = ST_JALR;
            OP_LUI:    tgt = ST_LUI;
            OP_AUIPC:  tgt = ST_AUIPC;
            default:   tgt = ST_FETCH;
        endcase
        return tgt;
    endfunction

    function automatic logic opcode_legal(input logic [6:0] op);
        return (decode_target(op) != ST_FETCH);
    endfunction

    logic [3:0] state_r;
    logic [3:0] next_state_s;

    logic       pc_write_s;
    logic       pc_write_cond_s;
    logic       pc_source_s;
    logic       iord_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic [1:0] mem_to_reg_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_co_s;
    logic       is_immediate_s;
    logic       instr_done_s;
    logic       illegal_s;

    // State register; reset returns to FETCH immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state selection; memory states wait on the ready handshake.
    always_comb begin
        next_state_s = ST_FETCH;
        case (state_r)
            ST_FETCH: begin
                if (mem_ready_i) begin
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE:   next_state_s = decode_target(instruction_opcode_i);
            ST_MEMADR: begin
                if (instruction_opcode_i == OP_LOAD) begin
                    next_state_s = ST_MEMREAD;
                end else begin
                    next_state_s = ST_MEMWRITE;
                end
            end
            ST_MEMREAD: begin
                if (mem_ready_i) begin
                    next_state_s = ST_MEMWB;
                end else begin
                    next_state_s = ST_MEMREAD;
                end
            end
            ST_MEMWB:    next_state_s = ST_FETCH;
            ST_MEMWRITE: begin
                if (mem_ready_i) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_MEMWRITE;
                end
            end
            ST_EXEC_R:   next_state_s = ST_ALUWB;
            ST_EXEC_I:   next_state_s = ST_ALUWB;
            ST_LUI:      next_state_s = ST_ALUWB;
            ST_AUIPC:    next_state_s = ST_ALUWB;
            ST_ALUWB:    next_state_s = ST_FETCH;
            ST_BRANCH:   next_state_s = ST_FETCH;
            ST_JAL:      next_state_s = ST_FETCH;
            ST_JALR:     next_state_s = ST_JALR_WB;
            ST_JALR_WB:  next_state_s = ST_FETCH;
            default:     next_state_s = ST_FETCH;
        endcase
    end

    // Per-state datapath control decode; anything not driven for a state stays 0.
    always_comb begin
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        pc_source_s     = 1'b0;
        iord_s          = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        reg_write_s     = 1'b0;
        mem_to_reg_s    = 2'b00;
        alu_src_a_s     = 2'b00;
        alu_src_b_s     = 2'b00;
        alu_co_s        = 2'b00;
        is_immediate_s  = 1'b0;
        instr_done_s    = 1'b0;
        illegal_s       = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                if (mem_ready_i) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                end else begin
                    ir_write_s = 1'b0;
                    pc_write_s = 1'b0;
                end
            end
            ST_DECODE: begin
                // Branch/JAL target is precomputed here from the old PC and the immediate.
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b10;
                if (!opcode_legal(instruction_opcode_i)) begin
                    illegal_s    = 1'b1;
                    instr_done_s = 1'b1;
                end else begin
                    illegal_s    = 1'b0;
                    instr_done_s = 1'b0;
                end
            end
            ST_MEMADR: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
            end
            ST_MEMREAD: begin
                iord_s     = 1'b1;
                mem_read_s = 1'b1;
            end
            ST_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 2'b01;
                instr_done_s = 1'b1;
            end
            ST_MEMWRITE: begin
                iord_s       = 1'b1;
                mem_write_s  = 1'b1;
                instr_done_s = mem_ready_i;
            end
            ST_EXEC_R: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b00;
                alu_co_s    = 2'b10;
            end
            ST_EXEC_I: begin
                alu_src_a_s    = 2'b01;
                alu_src_b_s    = 2'b10;
                alu_co_s       = 2'b10;
                is_immediate_s = 1'b1;
            end
            ST_LUI: begin
                alu_src_a_s = 2'b11;
                alu_src_b_s = 2'b10;
            end
            ST_AUIPC: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b10;
            end
            ST_ALUWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a_s     = 2'b01;
                alu_co_s        = 2'b01;
                pc_write_cond_s = 1'b1;
                pc_source_s     = 1'b1;
                instr_done_s    = 1'b1;
            end
            ST_JAL, ST_JALR_WB: begin
                // PC already holds old PC+4, so the PC writeback source is the link value.
                pc_write_s   = 1'b1;
                pc_source_s  = 1'b1;
                reg_write_s  = 1'b1;
                mem_to_reg_s = 2'b10;
                instr_done_s = 1'b1;
            end
            ST_JALR: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
            end
            default: begin
                pc_write_s = 1'b0;
            end
        endcase
    end

    // Write enables and strobes are forced low while reset is held.
    assign pc_write_o      = pc_write_s      & rst_n;
    assign pc_write_cond_o = pc_write_cond_s & rst_n;
    assign ir_write_o      = ir_write_s      & rst_n;
    assign reg_write_o     = reg_write_s     & rst_n;
    assign mem_read_o      = mem_read_s      & rst_n;
    assign mem_write_o     = mem_write_s     & rst_n;
    assign instr_done_o    = instr_done_s    & rst_n;
    assign illegal_o       = illegal_s       & rst_n;

    assign pc_source_o     = pc_source_s;
    assign iord_o          = iord_s;
    assign mem_to_reg_o    = mem_to_reg_s;
    assign alu_src_a_o     = alu_src_a_s;
    assign alu_src_b_o     = alu_src_b_s;
    assign alu_co_o        = alu_co_s;
    assign is_immediate_o  = is_immediate_s;
    assign state_o         = state_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed scoreboard bench for multicycle_control_fsm: each driven cycle pushes the
// expected state and control vector, a negedge checker pops and compares.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       ready;
    logic       pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write;
    logic       ir_write, reg_write, is_immediate, instr_done, illegal;
    logic [1:0] mem_to_reg, alu_src_a, alu_src_b, alu_co;
    logic [3:0] state;
    logic [18:0] obs;

    typedef struct packed {
        logic [3:0]  st;
        logic [18:0] out;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done_obs = 0;
    int   n_done_exp = 0;
    int   cyc = 0;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, ADD = 7'b0110011;
    localparam logic [6:0] ADDI = 7'b0010011, BEQ = 7'b1100011, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

    multicycle_control_fsm dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .instruction_opcode_i (opcode),
        .mem_ready_i          (ready),
        .pc_write_o           (pc_write),
        .pc_write_cond_o      (pc_write_cond),
        .pc_source_o          (pc_source),
        .iord_o               (iord),
        .mem_read_o           (mem_read),
        .mem_write_o          (mem_write),
        .ir_write_o           (ir_write),
        .reg_write_o          (reg_write),
        .mem_to_reg_o         (mem_to_reg),
        .alu_src_a_o          (alu_src_a),
        .alu_src_b_o          (alu_src_b),
        .alu_co_o             (alu_co),
        .is_immediate_o       (is_immediate),
        .instr_done_o         (instr_done),
        .illegal_o            (illegal),
        .state_o              (state)
    );

    assign obs = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
                  reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_co, is_immediate,
                  instr_done, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control vector for a state, written from the per-state output table.
    function automatic logic [18:0] exp_out(input logic [3:0] s, input logic rdy, input logic bad);
        logic pw, pwc, ps, io, mr, mw, irw, rw, imm, done, ill;
        logic [1:0] m2r, a, b, co;
        {pw, pwc, ps, io, mr, mw, irw, rw, imm, done, ill} = 11'b0;
        {m2r, a, b, co} = 8'b0;
        case (s)
            4'd0:  begin mr = 1'b1; b = 2'b01; irw = rdy; pw = rdy; end
            4'd1:  begin a = 2'b10; b = 2'b10; ill = bad; done = bad; end
            4'd2:  begin a = 2'b01; b = 2'b10; end
            4'd3:  begin io = 1'b1; mr = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 2'b01; done = 1'b1; end
            4'd5:  begin io = 1'b1; mw = 1'b1; done = rdy; end
            4'd6:  begin a = 2'b01; b = 2'b00; co = 2'b10; end
            4'd7:  begin a = 2'b01; b = 2'b10; co = 2'b10; imm = 1'b1; end
            4'd8:  begin rw = 1'b1; done = 1'b1; end
            4'd9:  begin a = 2'b01; co = 2'b01; pwc = 1'b1; ps = 1'b1; done = 1'b1; end
            4'd10, 4'd12: begin pw = 1'b1; ps = 1'b1; rw = 1'b1; m2r = 2'b10; done = 1'b1; end
            4'd11: begin a = 2'b01; b = 2'b10; end
            4'd13: begin a = 2'b11; b = 2'b10; end
            4'd14: begin a = 2'b10; b = 2'b10; end
            default: begin pw = 1'b0; end
        endcase
        return {pw, pwc, ps, io, mr, mw, irw, rw, m2r, a, b, co, imm, done, ill};
    endfunction

    // Scoreboard checker: compare the oldest expected record against the DUT mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            assert (state === e.st) else begin
                n_fail++;
                $error("FAIL state cyc=%0d observed=%0d expected=%0d", cyc, state, e.st);
            end
            n_checks++;
            assert (obs === e.out) else begin
                n_fail++;
                $error("FAIL ctrl st=%0d cyc=%0d observed=%b expected=%b", e.st, cyc, obs, e.out);
            end
            if (instr_done === 1'b1) n_done_obs++;
        end
    end

    // One cycle: after the edge, drive inputs and push what the DUT must show this cycle.
    task automatic step(input logic [3:0] st, input logic [6:0] opc, input logic rdy, input logic bad);
        @(posedge clk);
        #1;
        opcode = opc;
        ready  = rdy;
        sb_q.push_back('{st: st, out: exp_out(st, rdy, bad)});
    endtask

    task automatic run_instr(input logic [6:0] opc, input int fw, input int mw);
        logic [6:0] junk;
        repeat (fw) begin
            junk = 7'($urandom);
            step(4'd0, junk, 1'b0, 1'b0);
        end
        junk = 7'($urandom);
        step(4'd0, junk, 1'b1, 1'b0);
        case (opc)
            LW, SW, ADD, ADDI, BEQ, JAL, JALR, LUI, AUIPC:
                step(4'd1, opc, 1'($urandom_range(0, 1)), 1'b0);
            default:
                step(4'd1, opc, 1'($urandom_range(0, 1)), 1'b1);
        endcase
        junk = 7'($urandom);
        case (opc)
            LW: begin
                step(4'd2, opc, 1'($urandom_range(0, 1)), 1'b0);
                repeat (mw) step(4'd3, junk, 1'b0, 1'b0);
                step(4'd3, junk, 1'b1, 1'b0);
                step(4'd4, junk, 1'($urandom_range(0, 1)), 1'b0);
            end
            SW: begin
                step(4'd2, opc, 1'($urandom_range(0, 1)), 1'b0);
                repeat (mw) step(4'd5, junk, 1'b0, 1'b0);
                step(4'd5, junk, 1'b1, 1'b0);
            end
            ADD:   begin step(4'd6, junk, 1'b1, 1'b0); step(4'd8, junk, 1'b1, 1'b0); end
            ADDI:  begin step(4'd7, junk, 1'b0, 1'b0); step(4'd8, junk, 1'b0, 1'b0); end
            LUI:   begin step(4'd13, junk, 1'b1, 1'b0); step(4'd8, junk, 1'b0, 1'b0); end
            AUIPC: begin step(4'd14, junk, 1'b0, 1'b0); step(4'd8, junk, 1'b1, 1'b0); end
            BEQ:   step(4'd9, junk, 1'b1, 1'b0);
            JAL:   step(4'd10, junk, 1'b0, 1'b0);
            JALR:  begin step(4'd11, junk, 1'b1, 1'b0); step(4'd12, junk, 1'b0, 1'b0); end
            default: begin end
        endcase
        n_done_exp++;
    endtask

    initial begin
        rst_n  = 1'b0;
        ready  = 1'b0;
        opcode = 7'b0;
        #3;
        n_checks++;
        assert (state === 4'd0 && obs === {8'b0, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000}) else begin
            n_fail++;
            $error("FAIL reset_init observed st=%0d ctrl=%b expected st=0 ctrl=%b", state, obs,
                   {8'b0, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000});
        end
        #4 ready = 1'b1;
        #5;
        n_checks++;
        assert (state === 4'd0 && obs === {8'b0, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000}) else begin
            n_fail++;
            $error("FAIL reset_hold observed st=%0d ctrl=%b", state, obs);
        end
        ready = 1'b0;
        rst_n = 1'b1;
        #1;
        n_checks++;
        assert (mem_read === 1'b1 && iord === 1'b0 && ir_write === 1'b0) else begin
            n_fail++;
            $error("FAIL release_fetch observed mr=%b iord=%b irw=%b expected 1 0 0", mem_read, iord, ir_write);
        end

        run_instr(ADD, 0, 0);
        run_instr(LW, 3, 2);
        run_instr(SW, 0, 0);
        run_instr(BEQ, 0, 0);
        run_instr(JALR, 0, 0);
        run_instr(7'b0000000, 0, 0);
        run_instr(ADDI, 1, 0);
        run_instr(LUI, 0, 0);
        run_instr(AUIPC, 2, 0);
        run_instr(JAL, 0, 0);
        run_instr(SW, 0, 3);
        run_instr(7'b1111111, 1, 0);

        // Abort a load while MEMREAD is waiting on ready.
        step(4'd0, 7'h55, 1'b1, 1'b0);
        step(4'd1, LW, 1'b0, 1'b0);
        step(4'd2, LW, 1'b0, 1'b0);
        step(4'd3, 7'h0, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        assert (state === 4'd0 && obs === {8'b0, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000}) else begin
            n_fail++;
            $error("FAIL reset_mid observed st=%0d ctrl=%b", state, obs);
        end
        @(posedge clk);
        #2;
        n_checks++;
        assert (state === 4'd0 && mem_read === 1'b0 && reg_write === 1'b0 && instr_done === 1'b0) else begin
            n_fail++;
            $error("FAIL reset_mid_hold observed st=%0d mr=%b rw=%b done=%b", state, mem_read, reg_write, instr_done);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        assert (state === 4'd0 && mem_read === 1'b1 && iord === 1'b0) else begin
            n_fail++;
            $error("FAIL reset_mid_release observed st=%0d mr=%b iord=%b expected 0 1 0", state, mem_read, iord);
        end

        run_instr(ADDI, 0, 0);
        run_instr(LW, 0, 0);
        @(negedge clk);
        #1;
        n_checks++;
        assert (sb_q.size() == 0 && n_done_obs == n_done_exp) else begin
            n_fail++;
            $error("FAIL done_count observed=%0d expected=%0d pending=%0d", n_done_obs, n_done_exp, sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
